int_ctrl_seq: RTL

- Interrupt controller that sits at the device side of the sequencer's interrupt handshake.
- Edge-detects device interrupt requests, latches them as pending, applies the mask register and a global enable, and arbitrates.
- Presents intPending plus the vector address (HVPI) of the highest-valued pending, enabled interrupt.
- Tracks the in-service interrupt from clrPend (acknowledge) to intRet (end of ISR).

---
 rtl/int_pkg.sv | 20 ++
 rtl/prio_enc.sv | 23 ++
 rtl/int_ctrl_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/int_pkg.sv
// Shared constants and state encoding for the int_ctrl_seq interrupt controller.
package int_pkg;

    localparam int DEF_N_IRQ = 8;
    localparam logic [15:0] DEF_VEC_BASE = 16'h0010;
    localparam int DEF_VEC_STRIDE = 4;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARB     = 2'd1;
    localparam logic [1:0] S_PEND    = 2'd2;
    localparam logic [1:0] S_SERVICE = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = S_IDLE,
        ARB     = S_ARB,
        PEND    = S_PEND,
        SERVICE = S_SERVICE
    } state_t;

endpackage

// File: rtl/prio_enc.sv
// Highest-index-wins priority encoder: returns the index of the top set bit of req.
module prio_enc #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        // Ascending scan: the last set bit seen is the highest one.
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl_seq.sv
// Device-side interrupt controller: edge detect, pending/mask/enable, arbitration, in-service tracking.
// Define INT_NESTED_EN to let a higher-index interrupt preempt the one being serviced.
module int_ctrl_seq
    import int_pkg::*;
#(
    parameter int                 N_IRQ      = DEF_N_IRQ,
    parameter int                 ADDR_W     = 16,
    parameter logic [ADDR_W-1:0]  VEC_BASE   = ADDR_W'(DEF_VEC_BASE),
    parameter int                 VEC_STRIDE = DEF_VEC_STRIDE,
    parameter int                 IDW        = $clog2(N_IRQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IRQ-1:0]  irq,
    input  logic [N_IRQ-1:0]  maskIn,
    input  logic              MASKld,
    input  logic              MASKclr,
    input  logic              intEnable,
    input  logic              intDisable,
    input  logic              clrPend,
    input  logic              intRet,
    output logic              intPending,
    output logic [ADDR_W-1:0] hvpiAddr,
    output logic [IDW-1:0]    hvpiId,
    output logic [N_IRQ-1:0]  inService,
    output logic [1:0]        dbg_state
);

    // Handshake: intPending stays high from ARB->PEND until the cycle clrPend is
    // sampled in PEND; intRet is honoured only in SERVICE with inService != 0.

    state_t             state;
    logic [N_IRQ-1:0]   irq_prev;
    logic [N_IRQ-1:0]   pending;
    logic [N_IRQ-1:0]   mask;
    logic               global_en;

    logic [N_IRQ-1:0]   irq_rise;
    logic [N_IRQ-1:0]   eligible;
    logic [N_IRQ-1:0]   arb_req;
    logic [N_IRQ-1:0]   id_onehot;
    logic [N_IRQ-1:0]   pend_clr;
    logic [N_IRQ-1:0]   svc_after_ret;
    logic [IDW-1:0]     arb_idx;
    logic               arb_valid;
    logic [ADDR_W-1:0]  arb_addr;

    assign irq_rise  = irq & ~irq_prev;
    assign eligible  = pending & mask & {N_IRQ{global_en}};
    assign id_onehot = {{(N_IRQ-1){1'b0}}, 1'b1} << hvpiId;
    assign pend_clr  = (state == PEND && clrPend) ? id_onehot : '0;
    assign arb_addr  = VEC_BASE + ADDR_W'(VEC_STRIDE) * ADDR_W'(arb_idx);
    assign dbg_state = state;

`ifdef INT_NESTED_EN
    logic [IDW-1:0]   svc_idx;
    logic             svc_valid;
    logic [N_IRQ-1:0] above_svc;

    prio_enc #(.N(N_IRQ), .IW(IDW)) u_svc_enc (
        .req   (inService),
        .idx   (svc_idx),
        .valid (svc_valid)
    );

    // Only lines strictly above the top in-service line may preempt it.
    always_comb begin
        above_svc     = '1;
        svc_after_ret = inService;
        if (svc_valid) begin
            svc_after_ret[svc_idx] = 1'b0;
            for (int i = 0; i < N_IRQ; i++) begin
                above_svc[i] = (i > int'(svc_idx));
            end
        end
    end
    assign arb_req = eligible & above_svc;
`else
    assign arb_req       = eligible;
    assign svc_after_ret = '0;
`endif

    prio_enc #(.N(N_IRQ), .IW(IDW)) u_arb_enc (
        .req   (arb_req),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            irq_prev   <= '0;
            pending    <= '0;
            mask       <= '0;
            global_en  <= 1'b0;
            inService  <= '0;
            hvpiId     <= '0;
            hvpiAddr   <= VEC_BASE;
            intPending <= 1'b0;
        end else begin
            irq_prev <= irq;
            // A rising edge wins over an acknowledge clearing the same bit.
            pending  <= (pending & ~pend_clr) | irq_rise;

            if (MASKclr)
                mask <= '0;
            else if (MASKld)
                mask <= maskIn;

            if (intDisable)
                global_en <= 1'b0;
            else if (intEnable)
                global_en <= 1'b1;

            case (state)
                IDLE: begin
                    if (eligible != '0)
                        state <= ARB;
                end
                ARB: begin
                    if (arb_valid) begin
                        hvpiId     <= arb_idx;
                        hvpiAddr   <= arb_addr;
                        intPending <= 1'b1;
                        state      <= PEND;
                    end else if (inService != '0) begin
                        state <= SERVICE;
                    end else begin
                        state <= IDLE;
                    end
                end
                PEND: begin
                    if (clrPend) begin
                        inService  <= inService | id_onehot;
                        intPending <= 1'b0;
                        state      <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (intRet && inService != '0) begin
                        inService <= svc_after_ret;
                        if (svc_after_ret == '0)
                            state <= IDLE;
`ifdef INT_NESTED_EN
                    end else if (arb_req != '0) begin
                        state <= ARB;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
